// File: rtl/sram22_64x24_arbiter.sv
// sram22_64x24_arbiter
//   Two-port round-robin front end for the 64x24 single-port SRAM22 macro.
//   After every reset the whole array is zero-filled (one word per cycle), then
//   requesters A and B share the macro through valid/ready command handshakes.
//   Every accepted command (read or write) gets a one-cycle response pulse on its
//   own port exactly one cycle after acceptance.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   {a,b}_req_valid/ready            command handshake (accepted on valid & ready)
//   {a,b}_req_we/addr/wdata          command: 1 = write, word address, write data
//   {a,b}_rsp_valid/rdata            completion pulse, read data (0 for writes)
//   init_done                        high once the zero-fill has completed
//   sram_we/wmask/addr/din           macro inputs (this block is their only driver)
//   sram_dout                        macro read data (valid the cycle after a read)

module sram22_64x24_arbiter #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  init_done,
  output logic                  sram_we,
  output logic                  sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic {StInit, StServe} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_next;
  logic                  r_ptr, w_ptr_next;         // 0 = A has priority, 1 = B
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic                  r_rsp_port, w_rsp_port_next; // 0 = A, 1 = B
  logic                  r_rsp_we, w_rsp_we_next;
  logic                  w_grant_a, w_grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StInit;
      r_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_port  <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_ptr       <= w_ptr_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_port  <= w_rsp_port_next;
      r_rsp_we    <= w_rsp_we_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_ptr_next       = r_ptr;
    w_rsp_valid_next = 1'b0;
    w_rsp_port_next  = 1'b0;
    w_rsp_we_next    = 1'b0;
    w_grant_a        = 1'b0;
    w_grant_b        = 1'b0;
    a_req_ready      = 1'b0;
    b_req_ready      = 1'b0;
    init_done        = 1'b0;
    sram_we          = 1'b0;
    sram_wmask       = 1'b0;
    sram_addr        = '0;
    sram_din         = '0;

    // While rst is high the macro is kept idle and nothing is granted.
    if (!rst) begin
      unique case (r_state)
        StInit: begin
          sram_we    = 1'b1;
          sram_wmask = 1'b1;
          sram_addr  = r_cnt;
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == LastAddr) w_state_next = StServe;
        end
        StServe: begin
          init_done = 1'b1;
          w_grant_a = a_req_valid & (~b_req_valid | ~r_ptr);
          w_grant_b = b_req_valid & (~a_req_valid | r_ptr);
          if (w_grant_a) begin
            a_req_ready      = 1'b1;
            sram_we          = a_req_we;
            sram_wmask       = 1'b1;
            sram_addr        = a_req_addr;
            sram_din         = a_req_wdata;
            w_rsp_valid_next = 1'b1;
            w_rsp_port_next  = 1'b0;
            w_rsp_we_next    = a_req_we;
            w_ptr_next       = 1'b1;
          end else if (w_grant_b) begin
            b_req_ready      = 1'b1;
            sram_we          = b_req_we;
            sram_wmask       = 1'b1;
            sram_addr        = b_req_addr;
            sram_din         = b_req_wdata;
            w_rsp_valid_next = 1'b1;
            w_rsp_port_next  = 1'b1;
            w_rsp_we_next    = b_req_we;
            w_ptr_next       = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Responses: in-flight entries are suppressed while rst is high, and write
  // completions return zero so the macro's undefined write-cycle output never leaks.
  always_comb begin
    a_rsp_valid = ~rst & r_rsp_valid & ~r_rsp_port;
    b_rsp_valid = ~rst & r_rsp_valid & r_rsp_port;
    a_rsp_rdata = (a_rsp_valid && !r_rsp_we) ? sram_dout : '0;
    b_rsp_rdata = (b_rsp_valid && !r_rsp_we) ? sram_dout : '0;
  end

endmodule

// File: tb/tb_sram22_64x24_arbiter.sv
// tb_sram22_64x24_arbiter
//   Self-checking bench for sram22_64x24_arbiter. Contains a behavioural model of
//   the SRAM22 macro (1-cycle read latency, garbage output on write cycles), a
//   cycle-level reference model of the arbiter checked on every negedge, and
//   directed stimulus with hand-computed literal expectations.

module tb_sram22_64x24_arbiter;

  localparam int DW = 24;
  localparam int AW = 6;
  localparam int Depth = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          a_rsp_valid, b_rsp_valid;
  logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
  logic          init_done;
  logic          sram_we, sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram22_64x24_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_req_valid(a_req_valid),
    .a_req_ready(a_req_ready),
    .a_req_we   (a_req_we),
    .a_req_addr (a_req_addr),
    .a_req_wdata(a_req_wdata),
    .b_req_valid(b_req_valid),
    .b_req_ready(b_req_ready),
    .b_req_we   (b_req_we),
    .b_req_addr (b_req_addr),
    .b_req_wdata(b_req_wdata),
    .a_rsp_valid(a_rsp_valid),
    .a_rsp_rdata(a_rsp_rdata),
    .b_rsp_valid(b_rsp_valid),
    .b_rsp_rdata(b_rsp_rdata),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Macro model: contents start as garbage so a missing zero-fill shows up.
  logic [DW-1:0] mac_mem [Depth];
  initial begin
    for (int i = 0; i < Depth; i++) mac_mem[i] = 24'h5A5A5A;
    sram_dout = 24'h5A5A5A;
  end
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask) mac_mem[sram_addr] <= sram_din;
      sram_dout <= 24'hDEAD5A;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: filling flag and index, priority port, memory image and the
  // single expected response for the current cycle.
  bit          m_filling = 1'b1;
  int          m_fill = 0;
  int          m_prio = 0;                 // port that wins a tie: 0 = A, 1 = B
  logic [DW-1:0] m_mem [Depth];
  bit          m_rsp = 1'b0;
  int          m_rsp_port = 0;
  logic [DW-1:0] m_rsp_data = '0;

  always @(negedge clk) begin
    int            win;                    // -1 none, 0 A, 1 B
    bit            e_we, e_mask;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    win = -1;
    e_we = 1'b0; e_mask = 1'b0; e_addr = '0; e_din = '0;
    if (!rst && m_filling) begin
      e_we = 1'b1; e_mask = 1'b1; e_addr = AW'(m_fill);
    end else if (!rst) begin
      if (a_req_valid && b_req_valid) win = m_prio;
      else if (a_req_valid) win = 0;
      else if (b_req_valid) win = 1;
      if (win == 0) begin
        e_we = a_req_we; e_mask = 1'b1; e_addr = a_req_addr; e_din = a_req_wdata;
      end else if (win == 1) begin
        e_we = b_req_we; e_mask = 1'b1; e_addr = b_req_addr; e_din = b_req_wdata;
      end
    end
    chk("m_a_ready", 32'(a_req_ready), 32'(win == 0));
    chk("m_b_ready", 32'(b_req_ready), 32'(win == 1));
    chk("m_init_done", 32'(init_done), 32'(!rst && !m_filling));
    chk("m_sram_we", 32'(sram_we), 32'(e_we));
    chk("m_sram_wmask", 32'(sram_wmask), 32'(e_mask));
    chk("m_sram_addr", 32'(sram_addr), 32'(e_addr));
    chk("m_sram_din", 32'(sram_din), 32'(e_din));
    chk("m_a_rsp_valid", 32'(a_rsp_valid), 32'(!rst && m_rsp && m_rsp_port == 0));
    chk("m_b_rsp_valid", 32'(b_rsp_valid), 32'(!rst && m_rsp && m_rsp_port == 1));
    chk("m_a_rsp_rdata", 32'(a_rsp_rdata),
        (!rst && m_rsp && m_rsp_port == 0) ? 32'(m_rsp_data) : 32'd0);
    chk("m_b_rsp_rdata", 32'(b_rsp_rdata),
        (!rst && m_rsp && m_rsp_port == 1) ? 32'(m_rsp_data) : 32'd0);

    // Advance the model to the state after the coming posedge.
    m_rsp = 1'b0;
    if (rst) begin
      m_filling = 1'b1; m_fill = 0; m_prio = 0;
    end else if (m_filling) begin
      m_mem[m_fill] = '0;
      m_fill++;
      if (m_fill == Depth) m_filling = 1'b0;
    end else if (win >= 0) begin
      m_rsp = 1'b1;
      m_rsp_port = win;
      if (e_we) begin
        m_mem[e_addr] = e_din;
        m_rsp_data = '0;
      end else begin
        m_rsp_data = m_mem[e_addr];
      end
      m_prio = 1 - win;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic we, input int addr, input logic [DW-1:0] d);
    a_req_valid = v; a_req_we = we; a_req_addr = AW'(addr); a_req_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input int addr, input logic [DW-1:0] d);
    b_req_valid = v; b_req_we = we; b_req_addr = AW'(addr); b_req_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    set_a(1'b0, 1'b0, 0, '0);
    set_b(1'b0, 1'b0, 0, '0);
    repeat (3) step();

    // Zero-fill after reset release; this is cycle 0.
    rst = 1'b0;
    samp();
    chk("fill_c0_we", 32'(sram_we), 32'd1);
    chk("fill_c0_addr", 32'(sram_addr), 32'd0);
    chk("fill_c0_ready", 32'(a_req_ready | b_req_ready), 32'd0);
    repeat (63) step();
    samp();
    chk("fill_c63_addr", 32'(sram_addr), 32'd63);
    chk("fill_c63_done", 32'(init_done), 32'd0);
    step();
    samp();
    chk("fill_c64_done", 32'(init_done), 32'd1);
    step();

    // Read back the whole array through A.
    for (int i = 0; i < Depth; i++) begin
      set_a(1'b1, 1'b0, i, '0);
      if (i == 1) begin
        samp();
        chk("sweep_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("sweep_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
      end
      step();
    end

    // Single port write then read.
    set_a(1'b1, 1'b1, 5, 24'hABCDEF);
    samp();
    chk("sp_wr_ready", 32'(a_req_ready), 32'd1);
    step();
    set_a(1'b1, 1'b0, 5, '0);
    samp();
    chk("sp_wr_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("sp_wr_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    step();
    set_a(1'b0, 1'b0, 0, '0);
    samp();
    chk("sp_rd_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("sp_rd_rsp_rdata", 32'(a_rsp_rdata), 32'hABCDEF);
    chk("sp_rd_b_quiet", 32'(b_rsp_valid), 32'd0);
    step();

    // Cross-port read-after-write.
    set_b(1'b1, 1'b1, 63, 24'h123456);
    samp();
    chk("raw_b_ready", 32'(b_req_ready), 32'd1);
    step();
    set_b(1'b0, 1'b0, 0, '0);
    set_a(1'b1, 1'b0, 63, '0);
    step();
    set_a(1'b0, 1'b0, 0, '0);
    samp();
    chk("raw_a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("raw_a_rsp_rdata", 32'(a_rsp_rdata), 32'h123456);
    step();

    // Idle; the last grant was A, so the next tie must go to B.
    repeat (10) begin
      samp();
      chk("idle_we", 32'(sram_we), 32'd0);
      chk("idle_rsp", 32'(a_rsp_valid | b_rsp_valid), 32'd0);
      step();
    end
    set_a(1'b1, 1'b0, 5, '0);
    set_b(1'b1, 1'b0, 5, '0);
    samp();
    chk("idle_tie_b", 32'(b_req_ready), 32'd1);
    chk("idle_tie_not_a", 32'(a_req_ready), 32'd0);
    step();
    set_b(1'b0, 1'b0, 0, '0);
    step();
    set_a(1'b0, 1'b0, 0, '0);
    step();

    // Reset in the cycle a read is presented.
    set_a(1'b1, 1'b1, 10, 24'h777777);
    step();
    set_a(1'b1, 1'b0, 10, '0);
    rst = 1'b1;
    samp();
    chk("rst_no_ready", 32'(a_req_ready), 32'd0);
    chk("rst_done_low", 32'(init_done), 32'd0);
    step();
    rst = 1'b0;
    samp();
    chk("rst_no_rsp", 32'(a_rsp_valid | b_rsp_valid), 32'd0);
    chk("rst_refill_addr", 32'(sram_addr), 32'd0);
    chk("rst_refill_we", 32'(sram_we), 32'd1);
    step();
    repeat (63) step();

    // Contention straight after reset: A first, then alternate.
    set_b(1'b1, 1'b1, 20, 24'h0000B0);
    for (int i = 0; i < 6; i++) begin
      samp();
      chk("cont_a_ready", 32'(a_req_ready), 32'((i % 2) == 0));
      chk("cont_b_ready", 32'(b_req_ready), 32'((i % 2) == 1));
      if (i > 0) begin
        chk("cont_a_rsp", 32'(a_rsp_valid), 32'((i % 2) == 1));
        chk("cont_b_rsp", 32'(b_rsp_valid), 32'((i % 2) == 0));
      end
      if (i == 1) chk("cont_wiped_rdata", 32'(a_rsp_rdata), 32'd0);
      step();
    end
    set_a(1'b0, 1'b0, 0, '0);
    set_b(1'b0, 1'b0, 0, '0);
    samp();
    chk("cont_last_b_rsp", 32'(b_rsp_valid), 32'd1);
    chk("cont_last_b_rdata", 32'(b_rsp_rdata), 32'd0);
    step();
    set_a(1'b1, 1'b0, 20, '0);
    step();
    set_a(1'b0, 1'b0, 0, '0);
    samp();
    chk("cont_readback", 32'(a_rsp_rdata), 32'h0000B0);
    step();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
